ram_4096_arbiter: RTL and testbench

RAM_4096_ARBITER -- requirements
Module: ram_4096_arbiter

---
 rtl/ram_4096_pkg.sv | 21 ++
 rtl/ram_4096_arbiter_if.sv | 32 +++
 rtl/rr_arb2.sv | 34 +++
 rtl/ram_4096_arbiter.sv | 103 ++++++++++
 tb/tb_ram_4096_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_4096_pkg.sv
// rtl/ram_4096_pkg.sv - shared widths, requester index and read-tag types for the 4096-word RAM arbiter
package ram_4096_pkg;

    localparam int DATA_WIDTH_DEF = 64;
    localparam int ADDR_WIDTH_DEF = 12;
    localparam int NUM_REQ        = 2;

    typedef logic req_idx_t;

    typedef struct packed {
        logic     valid;
        req_idx_t idx;
    } rd_tag_t;

    localparam rd_tag_t RD_TAG_IDLE = '{valid: 1'b0, idx: 1'b0};

    function automatic logic [NUM_REQ-1:0] idx_onehot(input req_idx_t idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ram_4096_arbiter_if.sv
// rtl/ram_4096_arbiter_if.sv - requester-side bus of the RAM arbiter (two write and two read requesters)
interface ram_4096_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 12
);

    logic [1:0]                 wr_req;
    logic [1:0][ADDR_WIDTH-1:0] wr_addr;
    logic [1:0][DATA_WIDTH-1:0] wr_data;
    logic [1:0]                 wr_gnt;

    logic [1:0]                 rd_req;
    logic [1:0][ADDR_WIDTH-1:0] rd_addr;
    logic [1:0]                 rd_gnt;
    logic [1:0]                 rd_valid;
    logic [DATA_WIDTH-1:0]      rd_data;

    modport master (
        output wr_req, wr_addr, wr_data,
        input  wr_gnt,
        output rd_req, rd_addr,
        input  rd_gnt, rd_valid, rd_data
    );

    modport slave (
        input  wr_req, wr_addr, wr_data,
        output wr_gnt,
        input  rd_req, rd_addr,
        output rd_gnt, rd_valid, rd_data
    );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter; hold suppresses the grant and freezes priority
module rr_arb2
    import ram_4096_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req,
    input  logic       hold,
    output logic       win_valid,
    output req_idx_t   win_idx,
    output logic [1:0] gnt
);

    req_idx_t prio;

    // The winner is exposed ungated so the caller can inspect it before deciding to hold.
    always_comb begin
        win_valid = |req;
        win_idx   = req[prio] ? prio : ~prio;
        gnt       = 2'b00;
        if (resetn && win_valid && !hold) begin
            gnt = idx_onehot(win_idx);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prio <= 1'b0;
        end else if (|gnt) begin
            prio <= ~win_idx;
        end
    end

endmodule

// File: rtl/ram_4096_arbiter.sv
// rtl/ram_4096_arbiter.sv - shares one single-port-per-direction RAM between two writers and two readers
module ram_4096_arbiter
    import ram_4096_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
)
(
    input  logic                  clk,
    input  logic                  resetn,
    ram_4096_arbiter_if.slave     bus,
    output logic                  ram_write,
    output logic                  ram_read,
    output logic [ADDR_WIDTH-1:0] ram_wr_address,
    output logic [ADDR_WIDTH-1:0] ram_rd_address,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    input  logic [DATA_WIDTH-1:0] ram_data_out
);

    logic       wr_win_valid;
    req_idx_t   wr_win_idx;
    logic [1:0] wr_gnt;
    logic       rd_win_valid;
    req_idx_t   rd_win_idx;
    logic [1:0] rd_gnt;
    logic       addr_clash;
    rd_tag_t    tag_s1;
    rd_tag_t    tag_s2;

    rr_arb2 u_wr_arb (
        .clk       (clk),
        .resetn    (resetn),
        .req       (bus.wr_req),
        .hold      (1'b0),
        .win_valid (wr_win_valid),
        .win_idx   (wr_win_idx),
        .gnt       (wr_gnt)
    );

    // A read racing a same-cycle write to the same word waits a cycle so it sees the new data.
    always_comb begin
        addr_clash = 1'b0;
        if (wr_win_valid && rd_win_valid &&
            (bus.wr_addr[wr_win_idx] == bus.rd_addr[rd_win_idx])) begin
            addr_clash = 1'b1;
        end
    end

    rr_arb2 u_rd_arb (
        .clk       (clk),
        .resetn    (resetn),
        .req       (bus.rd_req),
        .hold      (addr_clash),
        .win_valid (rd_win_valid),
        .win_idx   (rd_win_idx),
        .gnt       (rd_gnt)
    );

    assign bus.wr_gnt = wr_gnt;
    assign bus.rd_gnt = rd_gnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ram_write      <= 1'b0;
            ram_wr_address <= '0;
            ram_data_in    <= '0;
        end else begin
            ram_write <= |wr_gnt;
            if (|wr_gnt) begin
                ram_wr_address <= bus.wr_addr[wr_win_idx];
                ram_data_in    <= bus.wr_data[wr_win_idx];
            end
        end
    end

    // Two tag stages line up with the RAM strobe cycle and the RAM output cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ram_read       <= 1'b0;
            ram_rd_address <= '0;
            tag_s1         <= RD_TAG_IDLE;
            tag_s2         <= RD_TAG_IDLE;
        end else begin
            ram_read   <= |rd_gnt;
            tag_s1.valid <= |rd_gnt;
            tag_s1.idx   <= rd_win_idx;
            tag_s2     <= tag_s1;
            if (|rd_gnt) begin
                ram_rd_address <= bus.rd_addr[rd_win_idx];
            end
        end
    end

    always_comb begin
        bus.rd_valid = 2'b00;
        bus.rd_data  = '0;
        if (tag_s2.valid) begin
            bus.rd_valid = idx_onehot(tag_s2.idx);
            bus.rd_data  = ram_data_out;
        end
    end

endmodule

// File: tb/tb_ram_4096_arbiter.sv
// tb/tb_ram_4096_arbiter.sv - self-checking bench for ram_4096_arbiter
module tb_ram_4096_arbiter;
    import ram_4096_pkg::*;

    localparam int DW = 64;
    localparam int AW = 12;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    ram_4096_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

    logic          ram_write;
    logic          ram_read;
    logic [AW-1:0] ram_wr_address;
    logic [AW-1:0] ram_rd_address;
    logic [DW-1:0] ram_data_in;
    logic [DW-1:0] ram_data_out = '0;

    ram_4096_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .bus            (bus),
        .ram_write      (ram_write),
        .ram_read       (ram_read),
        .ram_wr_address (ram_wr_address),
        .ram_rd_address (ram_rd_address),
        .ram_data_in    (ram_data_in),
        .ram_data_out   (ram_data_out)
    );

    logic [DW-1:0] ram_mem   [0:4095];
    logic [DW-1:0] model_mem [0:4095];

    always @(posedge clk) begin
        if (ram_write) ram_mem[ram_wr_address] <= ram_data_in;
        if (ram_read)  ram_data_out <= ram_mem[ram_rd_address];
    end

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        req_idx_t      idx;
        logic [DW-1:0] data;
        int            due;
    } sb_t;
    sb_t sbq[$];

    always @(negedge clk) begin
        sb_t e;
        if (!resetn) begin
            sbq.delete();
        end else begin
            check("wr_gnt_onehot0", 64'($onehot0(bus.wr_gnt)), 64'd1);
            check("rd_gnt_onehot0", 64'($onehot0(bus.rd_gnt)), 64'd1);
            if (bus.wr_gnt == 2'b01) model_mem[bus.wr_addr[0]] = bus.wr_data[0];
            if (bus.wr_gnt == 2'b10) model_mem[bus.wr_addr[1]] = bus.wr_data[1];
            if (bus.rd_valid != 2'b00) begin
                if (sbq.size() == 0) begin
                    check("sb_unexpected_rd_valid", 64'(bus.rd_valid), 64'd0);
                end else begin
                    e = sbq.pop_front();
                    check("sb_rd_valid", 64'(bus.rd_valid), 64'(idx_onehot(e.idx)));
                    check("sb_rd_data", bus.rd_data, e.data);
                    check("sb_rd_latency", 64'(cyc), 64'(e.due));
                end
            end
            if (bus.rd_gnt == 2'b01) sbq.push_back('{idx: 1'b0, data: model_mem[bus.rd_addr[0]], due: cyc + 2});
            if (bus.rd_gnt == 2'b10) sbq.push_back('{idx: 1'b1, data: model_mem[bus.rd_addr[1]], due: cyc + 2});
        end
    end

    typedef struct {
        logic [1:0]    wr_req;
        logic [1:0]    rd_req;
        logic [AW-1:0] wa0, wa1, ra0, ra1;
        logic [1:0]    ewg;
        logic [1:0]    erg;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    function automatic vec_t mkvec(input int i, input logic [1:0] w, input logic [1:0] r,
                                   input logic [1:0] ewg, input logic [1:0] erg);
        vec_t v;
        v.wr_req = w;
        v.rd_req = r;
        v.wa0 = AW'(32'h100 + i);
        v.wa1 = AW'(32'h180 + i);
        v.ra0 = AW'(32'h100 + i - 1);
        v.ra1 = AW'(32'h180 + i - 1);
        v.ewg = ewg;
        v.erg = erg;
        return v;
    endfunction

    task automatic idle_inputs();
        bus.wr_req  = 2'b00;
        bus.rd_req  = 2'b00;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.rd_addr = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_reset();
        step();
        resetn = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 4096; a++) begin
            ram_mem[a]   = '0;
            model_mem[a] = '0;
        end
        idle_inputs();
        bus.wr_req = 2'b11;
        bus.rd_req = 2'b11;

        // Reset state: requests pending, every output still zero.
        @(negedge clk);
        check("rst_wr_gnt", 64'(bus.wr_gnt), 64'd0);
        check("rst_rd_gnt", 64'(bus.rd_gnt), 64'd0);
        check("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
        check("rst_rd_data", bus.rd_data, 64'd0);
        check("rst_ram_write", 64'(ram_write), 64'd0);
        check("rst_ram_read", 64'(ram_read), 64'd0);
        check("rst_ram_wr_address", 64'(ram_wr_address), 64'd0);
        check("rst_ram_data_in", ram_data_in, 64'd0);

        // Grant table, starting on the first edge after reset release.
        for (int i = 0; i < 6; i++) vecs[i] = mkvec(i, 2'b11, 2'b11, (i % 2 == 0) ? 2'b01 : 2'b10,
                                                    (i % 2 == 0) ? 2'b01 : 2'b10);
        vecs[6]  = mkvec(6,  2'b10, 2'b00, 2'b10, 2'b00);
        vecs[7]  = mkvec(7,  2'b00, 2'b10, 2'b00, 2'b10);
        vecs[8]  = mkvec(8,  2'b00, 2'b00, 2'b00, 2'b00);
        vecs[9]  = mkvec(9,  2'b01, 2'b01, 2'b01, 2'b01);
        vecs[10] = mkvec(10, 2'b01, 2'b11, 2'b01, 2'b10);
        vecs[11] = mkvec(11, 2'b01, 2'b01, 2'b01, 2'b00);
        vecs[11].wa0 = 12'h055;
        vecs[11].ra0 = 12'h055;
        vecs[12] = mkvec(12, 2'b00, 2'b01, 2'b00, 2'b01);
        vecs[12].ra0 = 12'h055;
        vecs[13] = mkvec(13, 2'b01, 2'b11, 2'b01, 2'b00);
        vecs[13].wa0 = 12'h066;
        vecs[13].ra1 = 12'h066;
        vecs[14] = mkvec(14, 2'b00, 2'b11, 2'b00, 2'b10);
        vecs[14].ra1 = 12'h066;

        for (int i = 0; i < NVEC; i++) begin
            step();
            resetn = 1'b1;
            bus.wr_req     = vecs[i].wr_req;
            bus.rd_req     = vecs[i].rd_req;
            bus.wr_addr[0] = vecs[i].wa0;
            bus.wr_addr[1] = vecs[i].wa1;
            bus.rd_addr[0] = vecs[i].ra0;
            bus.rd_addr[1] = vecs[i].ra1;
            bus.wr_data[0] = {$urandom, $urandom};
            bus.wr_data[1] = {$urandom, $urandom};
            @(negedge clk);
            check($sformatf("vec%0d_wr_gnt", i), 64'(bus.wr_gnt), 64'(vecs[i].ewg));
            check($sformatf("vec%0d_rd_gnt", i), 64'(bus.rd_gnt), 64'(vecs[i].erg));
        end
        step();
        idle_inputs();
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("vec_sb_drained", 64'(sbq.size()), 64'd0);

        // Two writes then read-back, checking RAM strobes along the way.
        hold_reset();
        step();
        resetn = 1'b1;
        bus.wr_req = 2'b01; bus.wr_addr[0] = 12'h0A5; bus.wr_data[0] = 64'h1111;
        @(negedge clk);
        check("wr_r0_gnt", 64'(bus.wr_gnt), 64'b01);
        step();
        bus.wr_req = 2'b10; bus.wr_addr[1] = 12'h0A6; bus.wr_data[1] = 64'h2222;
        @(negedge clk);
        check("wr_r1_gnt", 64'(bus.wr_gnt), 64'b10);
        check("wr_r0_ram_write", 64'(ram_write), 64'd1);
        check("wr_r0_ram_addr", 64'(ram_wr_address), 64'h0A5);
        check("wr_r0_ram_data", ram_data_in, 64'h1111);
        step();
        bus.wr_req = 2'b00; bus.rd_req = 2'b01; bus.rd_addr[0] = 12'h0A5;
        @(negedge clk);
        check("rd_r0_gnt", 64'(bus.rd_gnt), 64'b01);
        check("wr_r1_ram_addr", 64'(ram_wr_address), 64'h0A6);
        step();
        bus.rd_req = 2'b10; bus.rd_addr[1] = 12'h0A6;
        @(negedge clk);
        check("rd_r1_gnt", 64'(bus.rd_gnt), 64'b10);
        check("wr_idle_ram_write", 64'(ram_write), 64'd0);
        check("rd_r0_ram_read", 64'(ram_read), 64'd1);
        check("rd_r0_ram_addr", 64'(ram_rd_address), 64'h0A5);
        step();
        bus.rd_req = 2'b00;
        @(negedge clk);
        check("rd_r0_valid", 64'(bus.rd_valid), 64'b01);
        check("rd_r0_data", bus.rd_data, 64'h1111);
        step();
        @(negedge clk);
        check("rd_r1_valid", 64'(bus.rd_valid), 64'b10);
        check("rd_r1_data", bus.rd_data, 64'h2222);
        step();
        @(negedge clk);
        check("rd_idle_valid", 64'(bus.rd_valid), 64'd0);
        check("rd_idle_ram_read", 64'(ram_read), 64'd0);
        check("rd_idle_ram_addr_hold", 64'(ram_rd_address), 64'h0A6);

        // Same-cycle write and read to one address: read waits and returns the new data.
        hold_reset();
        step();
        resetn = 1'b1;
        bus.wr_req = 2'b01; bus.wr_addr[0] = 12'h003; bus.wr_data[0] = 64'hBEEF;
        bus.rd_req = 2'b10; bus.rd_addr[1] = 12'h003;
        @(negedge clk);
        check("clash_wr_gnt", 64'(bus.wr_gnt), 64'b01);
        check("clash_rd_gnt_held", 64'(bus.rd_gnt), 64'b00);
        step();
        bus.wr_req = 2'b00;
        @(negedge clk);
        check("clash_rd_gnt_late", 64'(bus.rd_gnt), 64'b10);
        check("clash_ram_write", 64'(ram_write), 64'd1);
        step();
        bus.rd_req = 2'b00;
        @(negedge clk);
        check("clash_rd_valid_early", 64'(bus.rd_valid), 64'd0);
        step();
        @(negedge clk);
        check("clash_rd_valid", 64'(bus.rd_valid), 64'b10);
        check("clash_rd_data", bus.rd_data, 64'hBEEF);

        // Back-to-back reads from both requesters return in grant order.
        hold_reset();
        step();
        resetn = 1'b1;
        bus.wr_req = 2'b01; bus.wr_addr[0] = 12'h010; bus.wr_data[0] = 64'hAAAA_0010;
        @(negedge clk);
        check("b2b_wr0_gnt", 64'(bus.wr_gnt), 64'b01);
        step();
        bus.wr_addr[0] = 12'h020; bus.wr_data[0] = 64'hBBBB_0020;
        @(negedge clk);
        check("b2b_wr1_gnt", 64'(bus.wr_gnt), 64'b01);
        step();
        bus.wr_req = 2'b00;
        bus.rd_req = 2'b11; bus.rd_addr[0] = 12'h010; bus.rd_addr[1] = 12'h020;
        @(negedge clk);
        check("b2b_rd0_gnt", 64'(bus.rd_gnt), 64'b01);
        step();
        bus.rd_req = 2'b10;
        @(negedge clk);
        check("b2b_rd1_gnt", 64'(bus.rd_gnt), 64'b10);
        step();
        bus.rd_req = 2'b00;
        @(negedge clk);
        check("b2b_valid0", 64'(bus.rd_valid), 64'b01);
        check("b2b_data0", bus.rd_data, 64'hAAAA_0010);
        step();
        @(negedge clk);
        check("b2b_valid1", 64'(bus.rd_valid), 64'b10);
        check("b2b_data1", bus.rd_data, 64'hBBBB_0020);

        // Reset the cycle after a read grant: the read is dropped, priority returns to r0.
        hold_reset();
        step();
        resetn = 1'b1;
        bus.rd_req = 2'b10; bus.rd_addr[1] = 12'h0A5;
        @(negedge clk);
        check("rstfly_rd_gnt", 64'(bus.rd_gnt), 64'b10);
        step();
        resetn = 1'b0;
        bus.rd_req = 2'b00;
        @(negedge clk);
        check("rstfly_ram_read", 64'(ram_read), 64'd0);
        check("rstfly_rd_valid_rst", 64'(bus.rd_valid), 64'd0);
        check("rstfly_rd_gnt_rst", 64'(bus.rd_gnt), 64'd0);
        #1;
        resetn = 1'b1;
        step();
        bus.rd_req = 2'b11; bus.rd_addr[0] = 12'h0A6; bus.rd_addr[1] = 12'h0A5;
        @(negedge clk);
        check("rstfly_dropped_valid", 64'(bus.rd_valid), 64'd0);
        check("rstfly_next_gnt_r0", 64'(bus.rd_gnt), 64'b01);
        step();
        bus.rd_req = 2'b00;
        @(negedge clk);
        check("rstfly_valid_gap", 64'(bus.rd_valid), 64'd0);
        step();
        @(negedge clk);
        check("rstfly_new_valid", 64'(bus.rd_valid), 64'b01);
        check("rstfly_new_data", bus.rd_data, 64'h2222);

        step();
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("final_sb_drained", 64'(sbq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
